// File: rtl/result_bcd_converter.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock) for the ALU result bus.
// Define RESULT_BCD_SIGNED_EN to treat S as two's complement and report the sign separately.
module result_bcd_converter #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [WIDTH-1:0]      S,
  input  logic                  Cout,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  borrow_out,
  output logic                  sign
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] SHIFT = 2'b01;

  logic [1:0]          state;
  logic [WIDTH-1:0]    sreg;
  logic [4*DIGITS-1:0] dig, dig_adj, dig_next;
  logic [CW-1:0]       cnt;
  logic                borrow_l, sign_l;
  logic [WIDTH-1:0]    mag;
  logic                neg;

`ifdef RESULT_BCD_SIGNED_EN
  // The most negative value negates to itself, which reads correctly as an unsigned magnitude.
  assign neg = S[WIDTH-1];
  assign mag = neg ? (~S + 1'b1) : S;
`else
  assign neg = 1'b0;
  assign mag = S;
`endif

  for (genvar d = 0; d < DIGITS; d++) begin : g_adj
    assign dig_adj[4*d +: 4] = (dig[4*d +: 4] >= 4'd5) ? dig[4*d +: 4] + 4'd3 : dig[4*d +: 4];
  end

  assign dig_next = {dig_adj[4*DIGITS-2:0], sreg[WIDTH-1]};
  assign busy     = (state == SHIFT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      sreg       <= '0;
      dig        <= '0;
      cnt        <= '0;
      borrow_l   <= 1'b0;
      sign_l     <= 1'b0;
      done       <= 1'b0;
      bcd        <= '0;
      borrow_out <= 1'b0;
      sign       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sreg     <= mag;
            borrow_l <= Cout;
            sign_l   <= neg;
            dig      <= '0;
            cnt      <= WIDTH[CW-1:0];
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          dig  <= dig_next;
          sreg <= sreg << 1;
          cnt  <= cnt - 1'b1;
          // Final shift: publish results directly from the combinational next value.
          if (cnt == CW'(1)) begin
            bcd        <= dig_next;
            borrow_out <= borrow_l;
            sign       <= sign_l;
            done       <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_result_bcd_converter.sv
// Self-checking bench for result_bcd_converter: directed cases plus random conversions vs. a decimal model.
module tb_result_bcd_converter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  S = '0;
  logic        Cout = 1'b0;
  logic        busy, done, borrow_out, sign;
  logic [11:0] bcd;

  int tests = 0;
  int fails = 0;
  logic [11:0] prev_bcd = '0;

  result_bcd_converter #(.WIDTH(8), .DIGITS(3)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .S(S), .Cout(Cout),
    .busy(busy), .done(done), .bcd(bcd), .borrow_out(borrow_out), .sign(sign)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: decimal digits of the (possibly negated) value.
  task automatic model(input logic [7:0] s, output logic [11:0] b, output logic sg);
    int v;
    v  = s;
    sg = 1'b0;
`ifdef RESULT_BCD_SIGNED_EN
    if (s[7]) begin
      sg = 1'b1;
      v  = 256 - v;
    end
`endif
    b = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endtask

  // Starts a conversion in the current cycle; repulse >= 0 re-raises start with S=42 at that cycle.
  task automatic convert(input logic [7:0] s, input logic c, input int repulse, input string tag);
    logic [11:0] eb;
    logic        es;
    int          n;
    bit          busy_ok, hold_ok;
    model(s, eb, es);
    S = s; Cout = c; start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, "_busy_after_start"}, 32'(busy), 32'd1);
    n = 0; busy_ok = 1; hold_ok = 1;
    while (!done && n < 20) begin
      if (!busy) busy_ok = 0;
      if (bcd !== prev_bcd) hold_ok = 0;
      if (n == repulse) begin
        start = 1'b1; S = 8'd42; Cout = ~c;
      end else begin
        start = 1'b0; S = $urandom; Cout = $urandom;
      end
      tick();
      n++;
    end
    start = 1'b0;
    chk({tag, "_latency"}, 32'(n), 32'd8);
    chk({tag, "_busy_held"}, 32'(busy_ok), 32'd1);
    chk({tag, "_outputs_stable"}, 32'(hold_ok), 32'd1);
    chk({tag, "_busy_dropped"}, 32'(busy), 32'd0);
    chk({tag, "_bcd"}, 32'(bcd), 32'(eb));
    chk({tag, "_borrow"}, 32'(borrow_out), 32'(c));
    chk({tag, "_sign"}, 32'(sign), 32'(es));
    prev_bcd = eb;
  endtask

  initial begin
    logic [11:0] eb;
    logic        es;
    #12;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_bcd", 32'(bcd), 32'd0);
    chk("reset_borrow", 32'(borrow_out), 32'd0);
    chk("reset_sign", 32'(sign), 32'd0);
    rst_n = 1'b1;
    tick();

    convert(8'd0, 1'b0, -1, "zero");
    tick();
    convert(8'd255, 1'b0, -1, "max");
    tick();
    convert(8'd9, 1'b1, -1, "nine_borrow");
    tick();

    // Restart ignored while busy; exactly one done pulse.
    convert(8'd137, 1'b0, 2, "repulse");
    tick();
    chk("repulse_single_done", 32'(done), 32'd0);
    chk("repulse_idle", 32'(busy), 32'd0);
    chk("repulse_hold_bcd", 32'(bcd), 32'(prev_bcd));

    // Start raised in the done cycle is accepted.
    convert(8'd137, 1'b0, -1, "pre_done");
    convert(8'd42, 1'b0, -1, "in_done_cycle");

    // Asynchronous reset mid-conversion.
    tick();
    S = 8'd200; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    rst_n = 1'b0;
    #1;
    chk("midreset_busy", 32'(busy), 32'd0);
    chk("midreset_done", 32'(done), 32'd0);
    chk("midreset_bcd", 32'(bcd), 32'd0);
    chk("midreset_borrow", 32'(borrow_out), 32'd0);
    prev_bcd = '0;
    #3;
    rst_n = 1'b1;
    tick();
    convert(8'd7, 1'b0, -1, "after_reset");
    tick();

    convert(8'hF6, 1'b0, -1, "f6");
    tick();
    convert(8'h80, 1'b1, -1, "h80");
    tick();
    convert(8'h7F, 1'b0, -1, "h7f");
    tick();

    // Directed spot-checks of the model itself against hand values.
    model(8'd255, eb, es);
`ifdef RESULT_BCD_SIGNED_EN
    chk("model_ff", 32'(eb), 32'h001);
`else
    chk("model_ff", 32'(eb), 32'h255);
`endif

    for (int i = 0; i < 25; i++) begin
      convert(8'($urandom), 1'($urandom), -1, "rand");
      if ($urandom_range(1, 0) == 1) tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
